// File: rtl/cpu_sequencer.sv
// Single-clock instruction-phase sequencer for the GCore accumulator CPU.
// Optional single-step start is built only when GCORE_SEQ_STEP_EN is defined.
module cpu_sequencer #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step,
    output logic             opram_en,
    output logic             mem_en,
    output logic             alu_en,
    output logic             acc_en,
    output logic             pc_en,
    output logic             out_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MEM   = 3'd2,
        ALU   = 3'd3,
        ACC   = 3'd4,
        PC    = 3'd5,
        OUT   = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             halt_lat;
    logic             start_ok;
    logic             step_arm;

    assign tick = (div == DIV_W'(PRESCALE - 1));

    assign opram_en = (state == FETCH) && tick;
    assign mem_en   = (state == MEM)   && tick;
    assign alu_en   = (state == ALU)   && tick;
    assign acc_en   = (state == ACC)   && tick;
    assign pc_en    = (state == PC)    && tick;
    assign out_en   = (state == OUT)   && tick;

`ifdef GCORE_SEQ_STEP_EN
    logic step_q;
    logic step_edge;

    assign step_edge = step && !step_q;

    // Arming only happens in IDLE, so edges seen while busy are dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= 1'b0;
            step_arm <= 1'b0;
        end else begin
            step_q <= step;
            if (state_nxt == FETCH && state == IDLE)
                step_arm <= 1'b0;
            else if (state == IDLE && step_edge && !run && !halt_req)
                step_arm <= 1'b1;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
    assign step_arm    = 1'b0;
`endif

    assign start_ok = (run || step_arm) && !halt_req;

    always_comb begin
        state_nxt = state;
        if (tick) begin
            unique case (state)
                IDLE:    state_nxt = start_ok ? FETCH : IDLE;
                FETCH:   state_nxt = MEM;
                MEM:     state_nxt = ALU;
                ALU:     state_nxt = ACC;
                ACC:     state_nxt = PC;
                PC:      state_nxt = OUT;
                OUT:     state_nxt = (run && !halt_lat && !halt_req) ? FETCH : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            halt_lat  <= 1'b0;
            instr_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase     <= '0;
        end else begin
            state <= state_nxt;
            div   <= tick ? '0 : div + DIV_W'(1);

            if (state != IDLE && state_nxt == IDLE)
                halt_lat <= 1'b0;
            else if (halt_req && busy)
                halt_lat <= 1'b1;

            if (out_en)
                instr_cnt <= instr_cnt + CNT_W'(1);

            // Status mirrors the state register, so it is loaded from the next state.
            busy  <= (state_nxt != IDLE);
            phase <= state_nxt;
            done  <= out_en && (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: three instances (P=1/W=8, P=4/W=8, P=1/W=4)
// share stimulus; expected phase/enable/count values come from a cycle-index model.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst, run, halt_req, step;

    logic       op_a, mem_a, alu_a, acc_a, pc_a, out_a, busy_a, done_a;
    logic [2:0] ph_a;
    logic [7:0] cnt_a;
    logic       op_b, mem_b, alu_b, acc_b, pc_b, out_b, busy_b, done_b;
    logic [2:0] ph_b;
    logic [7:0] cnt_b;
    logic       op_c, mem_c, alu_c, acc_c, pc_c, out_c, busy_c, done_c;
    logic [2:0] ph_c;
    logic [3:0] cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PRESCALE(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .step(step),
        .opram_en(op_a), .mem_en(mem_a), .alu_en(alu_a), .acc_en(acc_a),
        .pc_en(pc_a), .out_en(out_a), .busy(busy_a), .done(done_a),
        .phase(ph_a), .instr_cnt(cnt_a)
    );

    cpu_sequencer #(.PRESCALE(4), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .step(step),
        .opram_en(op_b), .mem_en(mem_b), .alu_en(alu_b), .acc_en(acc_b),
        .pc_en(pc_b), .out_en(out_b), .busy(busy_b), .done(done_b),
        .phase(ph_b), .instr_cnt(cnt_b)
    );

    cpu_sequencer #(.PRESCALE(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .step(step),
        .opram_en(op_c), .mem_en(mem_c), .alu_en(alu_c), .acc_en(acc_c),
        .pc_en(pc_c), .out_en(out_c), .busy(busy_c), .done(done_c),
        .phase(ph_c), .instr_cnt(cnt_c)
    );

    wire [10:0] vec_a = {busy_a, done_a, ph_a, out_a, pc_a, acc_a, alu_a, mem_a, op_a};
    wire [10:0] vec_b = {busy_b, done_b, ph_b, out_b, pc_b, acc_b, alu_b, mem_b, op_b};
    wire [10:0] vec_c = {busy_c, done_c, ph_c, out_c, pc_c, acc_c, alu_c, mem_c, op_c};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
        end
    endtask

    // Sample half a period after the rising edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Continuous run released at cycle 0: first FETCH cycle is k=P; each state lasts P cycles.
    function automatic logic [10:0] exp_vec(input int p, input int k);
        int t, s;
        logic [5:0] en;
        if (k < p) return '0;
        t  = (k - p) / p;
        s  = t % 6;
        en = (((k - p) % p) == p - 1) ? 6'(1 << s) : 6'd0;
        return {1'b1, 1'b0, 3'(s + 1), en};
    endfunction

    function automatic int exp_cnt(input int p, input int k);
        if (k < p) return 0;
        return ((k - p) / p) / 6;
    endfunction

    initial begin
        int pulses;

        // Reset state and continuous run for all three instances
        do_reset();
        check("rst_vec_a", 32'(vec_a), 0);
        check("rst_cnt_a", 32'(cnt_a), 0);
        check("rst_vec_b", 32'(vec_b), 0);
        check("rst_cnt_c", 32'(cnt_c), 0);
        run = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            cyc();
            check($sformatf("vec_a_k%0d", k), 32'(vec_a), 32'(exp_vec(1, k)));
            check($sformatf("cnt_a_k%0d", k), 32'(cnt_a), 32'(exp_cnt(1, k) % 256));
            check($sformatf("vec_b_k%0d", k), 32'(vec_b), 32'(exp_vec(4, k)));
            check($sformatf("cnt_b_k%0d", k), 32'(cnt_b), 32'(exp_cnt(4, k) % 256));
            check($sformatf("vec_c_k%0d", k), 32'(vec_c), 32'(exp_vec(1, k)));
            check($sformatf("cnt_c_k%0d", k), 32'(cnt_c), 32'(exp_cnt(1, k) % 16));
        end

        // Halt request during ALU of instruction 3, then run dropped mid-instruction
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 15; k++) cyc();
        check("halt_in_alu", 32'(ph_a), 3);
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        cyc();
        cyc();
        check("halt_out_en", 32'(out_a), 1);
        cyc();
        check("halt_done", 32'(done_a), 1);
        check("halt_busy", 32'(busy_a), 0);
        check("halt_cnt", 32'(cnt_a), 3);
        check("halt_phase", 32'(ph_a), 0);
        cyc();
        check("restart_fetch", 32'(op_a), 1);
        check("restart_done", 32'(done_a), 0);
        cyc();
        run = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        check("rundrop_done", 32'(vec_a), 32'b0_1_000_000000);
        check("rundrop_cnt", 32'(cnt_a), 4);
        cyc();
        check("rundrop_idle", 32'(vec_a), 0);

        // halt_req held in IDLE blocks the start
        do_reset();
        run = 1'b1;
        halt_req = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        check("blocked_vec", 32'(vec_a), 0);
        halt_req = 1'b0;
        cyc();
        check("unblocked_fetch", 32'(vec_a), 32'b1_0_001_000001);

        // Reset during ACC of instruction 2 aborts immediately
        do_reset();
        run = 1'b1;
        for (int k = 1; k <= 10; k++) cyc();
        check("pre_abort_phase", 32'(ph_a), 4);
        check("pre_abort_cnt", 32'(cnt_a), 1);
        rst = 1'b1;
        cyc();
        check("abort_vec", 32'(vec_a), 0);
        check("abort_cnt", 32'(cnt_a), 0);
        rst = 1'b0;
        run = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            pulses += int'(pc_a) + int'(out_a) + int'(busy_a);
        end
        check("abort_no_tail", 32'(pulses), 0);

`ifdef GCORE_SEQ_STEP_EN
        // Step held high, then a second edge while busy: exactly one instruction
        do_reset();
        step = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            pulses += int'(op_a);
            if (k == 5) step = 1'b0;
            if (k == 6) step = 1'b1;
        end
        check("step_fetches", 32'(pulses), 1);
        check("step_cnt", 32'(cnt_a), 1);
        check("step_idle", 32'(busy_a), 0);
`else
        // Step ignored when single-step is not built
        do_reset();
        step = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            pulses += int'(op_a) + int'(busy_a);
            if (k == 3) step = 1'b0;
            if (k == 6) step = 1'b1;
        end
        check("step_ignored", 32'(pulses), 0);
        check("step_ignored_cnt", 32'(cnt_a), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
